// File: rtl/timer_period_decoder_pkg.sv
// Constants and state encoding shared by the periodic-pulse timer and its receive-side decoder.
package timer_period_decoder_pkg;

  localparam int unsigned PERIOD_MIN = 8;
  localparam int unsigned PERIOD_MAX = 1024;
  localparam int unsigned NUM_SEL    = 8;
  localparam int unsigned SEL_W      = 3;

  typedef enum logic [1:0] {
    StIdle,
    StMeas,
    StTrack,
    StLocked
  } state_e;

  // Selector k maps to a period of 2^(k+3) cycles.
  function automatic int unsigned sel_to_period(int unsigned sel);
    return PERIOD_MIN << sel;
  endfunction

endpackage

// File: rtl/timer_period_decoder_period_classify.sv
// Combinational interval classifier: interval -> {legal, k}.
// PERIOD_DECODER_TOL_EN widens each legal period to +/-1 cycle.
module timer_period_decoder_period_classify
  import timer_period_decoder_pkg::*;
#(
  parameter int unsigned IW = 12
) (
  input  logic [IW-1:0]    interval,
  output logic             legal,
  output logic [SEL_W-1:0] sel
);

  logic [IW-1:0] per [NUM_SEL];

  for (genvar g = 0; g < NUM_SEL; g++) begin : g_per
    assign per[g] = IW'(sel_to_period(g));
  end

  always_comb begin
    legal = 1'b0;
    sel   = '0;
    for (int unsigned k = 0; k < NUM_SEL; k++) begin
`ifdef PERIOD_DECODER_TOL_EN
      // Tolerance windows of neighbouring periods never overlap.
      if ((interval >= per[k[SEL_W-1:0]] - IW'(1)) &&
          (interval <= per[k[SEL_W-1:0]] + IW'(1))) begin
`else
      if (interval == per[k[SEL_W-1:0]]) begin
`endif
        legal = 1'b1;
        sel   = k[SEL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/timer_period_decoder.sv
// Receive side of the periodic-pulse timer link: recovers the selector from the pulse spacing.
// PERIOD_DECODER_TOL_EN: accept +/-1 cycle jitter and move the timeout threshold to 1026.
module timer_period_decoder
  import timer_period_decoder_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 3,
  parameter int unsigned CNT_W      = 11
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pulse_in,
  output logic [SEL_W-1:0] sel_out,
  output logic             locked,
  output logic             period_err
);

`ifdef PERIOD_DECODER_TOL_EN
  localparam int unsigned CntSat = PERIOD_MAX + 2;
`else
  localparam int unsigned CntSat = PERIOD_MAX + 1;
`endif
  localparam logic [CNT_W-1:0] CntMax  = CNT_W'(CntSat);
  localparam int unsigned      MatchW  = 4;
  localparam logic [MatchW-1:0] LockCnt = MatchW'(LOCK_COUNT);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MatchW-1:0]   match_q, match_d;
  logic [SEL_W-1:0]    cand_q, cand_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic                locked_q, locked_d;
  logic                err_q, err_d;

  logic [CNT_W:0]      interval;
  logic                legal;
  logic [SEL_W-1:0]    k;
  logic                timeout;
  logic                same_as_locked;

  assign interval = {1'b0, cnt_q} + (CNT_W + 1)'(1);

  timer_period_decoder_period_classify #(
    .IW (CNT_W + 1)
  ) u_classify (
    .interval (interval),
    .legal    (legal),
    .sel      (k)
  );

  // A pulse in the same cycle overrides the timeout.
  assign timeout        = !pulse_in && (cnt_q == CntMax) && (state_q != StIdle);
  assign same_as_locked = legal && (k == sel_q);

  always_comb begin
    cnt_d = cnt_q;
    if (pulse_in) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      match_q  <= '0;
      cand_q   <= '0;
      sel_q    <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      match_q  <= match_d;
      cand_q   <= cand_d;
      sel_q    <= sel_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    match_d = match_q;
    cand_d  = cand_q;
    if (pulse_in) begin
      unique case (state_q)
        StIdle: begin
          state_d = StMeas;
        end
        StMeas: begin
          if (legal) begin
            state_d = StTrack;
            cand_d  = k;
            match_d = MatchW'(1);
          end
        end
        StTrack: begin
          if (!legal) begin
            state_d = StMeas;
            match_d = '0;
          end else if (k == cand_q) begin
            match_d = match_q + MatchW'(1);
          end else begin
            cand_d  = k;
            match_d = MatchW'(1);
          end
        end
        StLocked: begin
          if (!same_as_locked) begin
            if (legal) begin
              state_d = StTrack;
              cand_d  = k;
              match_d = MatchW'(1);
            end else begin
              state_d = StMeas;
              match_d = '0;
            end
          end
        end
        default: begin
          state_d = StIdle;
          match_d = '0;
        end
      endcase
    end else if (timeout) begin
      state_d = StIdle;
      match_d = '0;
    end
    // Lock as soon as the run of identical intervals is long enough (covers LOCK_COUNT=1).
    if ((state_d == StTrack) && (match_d == LockCnt)) begin
      state_d = StLocked;
    end
  end

  // Output logic; outputs are registered, so these are next values.
  always_comb begin
    locked_d = (state_d == StLocked);
    sel_d    = (state_d == StLocked) ? cand_d : sel_q;
    err_d    = (state_q == StLocked) && (timeout || (pulse_in && !same_as_locked));
  end

  assign sel_out    = sel_q;
  assign locked     = locked_q;
  assign period_err = err_q;

endmodule

// File: tb/tb_timer_period_decoder.sv
// Self-checking bench for timer_period_decoder: directed scenarios plus randomized pulse trains
// compared against a time-based reference model.
module tb_timer_period_decoder;

  localparam int LOCK_N = 3;
`ifdef PERIOD_DECODER_TOL_EN
  localparam int TOL    = 1;
  localparam int CNTMAX = 1026;
`else
  localparam int TOL    = 0;
  localparam int CNTMAX = 1025;
`endif

  logic       clock;
  logic       reset;
  logic       pulse_in;
  logic [2:0] sel_out;
  logic       locked;
  logic       period_err;

  timer_period_decoder #(
    .LOCK_COUNT (LOCK_N),
    .CNT_W      (11)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pulse_in   (pulse_in),
    .sel_out    (sel_out),
    .locked     (locked),
    .period_err (period_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int drv_last = 0;
  int err_seen = 0;

  // Reference model: phase 0 idle, 1 measuring, 2 tracking a run, 3 locked.
  int         m_phase = 0;
  int         m_last  = 0;
  int         m_run_k = 0;
  int         m_run_n = 0;
  logic [2:0] exp_sel = 3'd0;
  logic       exp_locked = 1'b0;
  logic       exp_err = 1'b0;

  function automatic int classify(int iv);
    for (int kk = 0; kk < 8; kk++) begin
      int p;
      p = 8 << kk;
      if (iv >= p - TOL && iv <= p + TOL) return kk;
    end
    return -1;
  endfunction

  function automatic void model_step(logic p, logic r);
    int gap;
    int iv;
    int kk;
    exp_err = 1'b0;
    if (r) begin
      m_phase = 0; m_run_n = 0; m_last = cyc;
      exp_sel = 3'd0; exp_locked = 1'b0;
    end else begin
      gap = cyc - m_last;
      iv  = (gap > CNTMAX + 1) ? CNTMAX + 1 : gap;
      if (p) begin
        kk = classify(iv);
        case (m_phase)
          0: m_phase = 1;
          1: if (kk >= 0) begin m_phase = 2; m_run_k = kk; m_run_n = 1; end
          2: begin
            if (kk < 0) begin m_phase = 1; m_run_n = 0; end
            else if (kk == m_run_k) m_run_n++;
            else begin m_run_k = kk; m_run_n = 1; end
          end
          default: begin
            if (!(kk >= 0 && kk == int'(exp_sel))) begin
              exp_err = 1'b1; exp_locked = 1'b0;
              if (kk >= 0) begin m_phase = 2; m_run_k = kk; m_run_n = 1; end
              else begin m_phase = 1; m_run_n = 0; end
            end
          end
        endcase
        m_last = cyc;
      end else if (m_phase != 0 && gap - 1 >= CNTMAX) begin
        if (m_phase == 3) exp_err = 1'b1;
        m_phase = 0; m_run_n = 0; exp_locked = 1'b0;
      end
      if (m_phase == 2 && m_run_n >= LOCK_N) begin
        m_phase = 3; exp_sel = 3'(m_run_k); exp_locked = 1'b1;
      end
    end
    cyc++;
  endfunction

  task automatic tick(input logic p, input logic r);
    @(negedge clock);
    pulse_in = p;
    reset    = r;
    if (p && !r) drv_last = cyc;
    @(posedge clock);
    model_step(p, r);
    #1;
    if (period_err) err_seen++;
  endtask

  task automatic pulse_gap(input int g);
    while (cyc < drv_last + g) tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
  endtask

  task automatic do_reset();
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b0);
  endtask

  task automatic test_reset();
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    n_cmp++; if (sel_out !== 3'd0) begin n_bad++; $display("FAIL reset_sel got %0d want 0", sel_out); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked got %b want 0", locked); end
    n_cmp++; if (period_err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", period_err); end
  endtask

  task automatic test_lock_sel0();
    do_reset();
    tick(1'b1, 1'b0);
    pulse_gap(8);
    pulse_gap(8);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL sel0_early_lock got %b want 0", locked); end
    pulse_gap(8);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL sel0_locked got %b want 1", locked); end
    n_cmp++; if (sel_out !== 3'd0) begin n_bad++; $display("FAIL sel0_sel got %0d want 0", sel_out); end
  endtask

  task automatic test_switch();
    do_reset();
    tick(1'b1, 1'b0);
    repeat (3) pulse_gap(1024);
    n_cmp++; if (locked !== 1'b1 || sel_out !== 3'd7) begin
      n_bad++; $display("FAIL switch_lock7 got locked=%b sel=%0d want 1/7", locked, sel_out);
    end
    err_seen = 0;
    pulse_gap(32);
    n_cmp++; if (period_err !== 1'b1 || locked !== 1'b0) begin
      n_bad++; $display("FAIL switch_strobe got err=%b locked=%b want 1/0", period_err, locked);
    end
    tick(1'b0, 1'b0);
    n_cmp++; if (period_err !== 1'b0) begin n_bad++; $display("FAIL switch_strobe_len got %b want 0", period_err); end
    pulse_gap(32);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL switch_early_relock got %b want 0", locked); end
    pulse_gap(32);
    n_cmp++; if (locked !== 1'b1 || sel_out !== 3'd2) begin
      n_bad++; $display("FAIL switch_relock2 got locked=%b sel=%0d want 1/2", locked, sel_out);
    end
    n_cmp++; if (err_seen !== 1) begin n_bad++; $display("FAIL switch_err_count got %0d want 1", err_seen); end
  endtask

  task automatic test_timeout();
    int t0;
    int c;
    int fall;
    do_reset();
    tick(1'b1, 1'b0);
    repeat (3) pulse_gap(16);
    n_cmp++; if (locked !== 1'b1 || sel_out !== 3'd1) begin
      n_bad++; $display("FAIL timeout_lock16 got locked=%b sel=%0d want 1/1", locked, sel_out);
    end
    t0 = drv_last;
    fall = -1;
    err_seen = 0;
    for (int n = 0; n < 1200; n++) begin
      c = cyc;
      tick(1'b0, 1'b0);
      if (!locked) begin fall = c; break; end
    end
    n_cmp++; if (fall != t0 + CNTMAX + 1) begin
      n_bad++; $display("FAIL timeout_when got cycle %0d want %0d", fall, t0 + CNTMAX + 1);
    end
    n_cmp++; if (period_err !== 1'b1) begin n_bad++; $display("FAIL timeout_err got %b want 1", period_err); end
    repeat (20) tick(1'b0, 1'b0);
    n_cmp++; if (err_seen !== 1 || sel_out !== 3'd1) begin
      n_bad++; $display("FAIL timeout_after got errs=%0d sel=%0d want 1/1", err_seen, sel_out);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    err_seen = 0;
    tick(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      pulse_gap(12);
      n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL illegal12_locked #%0d got %b want 0", i, locked); end
    end
    n_cmp++; if (err_seen !== 0) begin n_bad++; $display("FAIL illegal12_err got %0d want 0", err_seen); end
`ifdef PERIOD_DECODER_TOL_EN
    do_reset();
    tick(1'b1, 1'b0);
    repeat (3) pulse_gap(17);
    n_cmp++; if (locked !== 1'b1 || sel_out !== 3'd1) begin
      n_bad++; $display("FAIL tol17 got locked=%b sel=%0d want 1/1", locked, sel_out);
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    tick(1'b1, 1'b0);
    repeat (3) pulse_gap(8);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre got %b want 1", locked); end
    tick(1'b1, 1'b1);
    n_cmp++; if (locked !== 1'b0 || sel_out !== 3'd0 || period_err !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_outs got l=%b s=%0d e=%b want 0/0/0", locked, sel_out, period_err);
    end
    tick(1'b0, 1'b0);
    tick(1'b1, 1'b0);
    repeat (LOCK_N - 1) pulse_gap(8);
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL rstmid_early got %b want 0", locked); end
    pulse_gap(8);
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL rstmid_relock got %b want 1", locked); end
  endtask

  task automatic test_cnt_edge();
    do_reset();
    tick(1'b1, 1'b0);
    repeat (3) pulse_gap(1024);
    err_seen = 0;
    pulse_gap(CNTMAX + 1);
    n_cmp++; if (period_err !== 1'b1 || locked !== 1'b0) begin
      n_bad++; $display("FAIL edge_strobe got err=%b locked=%b want 1/0", period_err, locked);
    end
    // From MEAS three legal intervals relock; from IDLE it would take four pulses.
    repeat (3) pulse_gap(1024);
    n_cmp++; if (locked !== 1'b1 || sel_out !== 3'd7) begin
      n_bad++; $display("FAIL edge_meas_relock got locked=%b sel=%0d want 1/7", locked, sel_out);
    end
    n_cmp++; if (err_seen !== 1) begin n_bad++; $display("FAIL edge_err_count got %0d want 1", err_seen); end
  endtask

  task automatic test_random();
    int gaps [11];
    int cur;
    logic p;
    logic r;
    gaps = '{8, 16, 32, 64, 7, 9, 15, 17, 12, 1, 3};
    do_reset();
    cur = 8;
    for (int i = 0; i < 6000; i++) begin
      r = ($urandom_range(0, 599) == 0);
      p = (cyc >= drv_last + cur) || ($urandom_range(0, 199) == 0);
      if (p && !r && $urandom_range(0, 3) == 0) cur = gaps[$urandom_range(0, 10)];
      tick(p, r);
      n_cmp++; if (locked !== exp_locked) begin
        n_bad++; $display("FAIL rand_locked cyc %0d got %b want %b", cyc, locked, exp_locked);
      end
      n_cmp++; if (sel_out !== exp_sel) begin
        n_bad++; $display("FAIL rand_sel cyc %0d got %0d want %0d", cyc, sel_out, exp_sel);
      end
      n_cmp++; if (period_err !== exp_err) begin
        n_bad++; $display("FAIL rand_err cyc %0d got %b want %b", cyc, period_err, exp_err);
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    pulse_in = 1'b0;
    test_reset();
    test_lock_sel0();
    test_switch();
    test_timeout();
    test_illegal();
    test_reset_mid();
    test_cnt_edge();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
